addroundkey_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 21 ++
 rtl/addroundkey_col.sv | 12 +
 rtl/addroundkey_seq.sv | 146 ++++++++++++++
 tb/tb_addroundkey_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, state type, FSM encoding and column select helper
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int COL_W   = 32;

  typedef logic [BLOCK_W-1:0] state_t;
  typedef logic [COL_W-1:0]   col_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fsm_t;

  // Column 0 occupies the most significant 32 bits of the block.
  function automatic col_t col_sel(input state_t s, input logic [1:0] idx);
    return s[BLOCK_W-1-COL_W*int'(idx) -: COL_W];
  endfunction

endpackage

// File: rtl/addroundkey_col.sv
// rtl/addroundkey_col.sv - XOR of one 32-bit state column with one key column
module addroundkey_col
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] state_col,
  input  logic [COL_W-1:0] key_col,
  output logic [COL_W-1:0] out_col
);

  assign out_col = state_col ^ key_col;

endmodule

// File: rtl/addroundkey_seq.sv
// rtl/addroundkey_seq.sv - column-serial AES AddRoundKey with local round-key store
module addroundkey_seq
  import aes_pkg::*;
#(
  parameter  int NR             = 10,
  parameter  int COLS_PER_CYCLE = 4,
  localparam int RW             = $clog2(NR + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_we,
  input  logic [RW-1:0]      key_waddr,
  input  logic [BLOCK_W-1:0] key_wdata,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_state,
  input  logic [RW-1:0]      in_round,
  input  logic               in_decrypt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_state,
  output logic [RW-1:0]      out_round,
  output logic               out_err,
  output logic               busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("addroundkey_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Counter value seen in the final RUN cycle; the step wraps to 0 when all four columns go at once.
  localparam logic [1:0]    LAST_CNT = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0]    STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [RW-1:0] NR_IDX   = RW'(NR);

  fsm_t          state_q;
  fsm_t          state_d;
  logic [1:0]    cnt;
  state_t        work_state;
  state_t        work_key;
  logic [RW-1:0] round_q;
  logic          err_q;

  state_t        key_mem [NR+1];

  logic          accept;
  logic          req_err;
  logic [RW-1:0] slot;
  state_t        slot_key;

  logic [1:0]    col_idx [COLS_PER_CYCLE];
  col_t          xor_col [COLS_PER_CYCLE];

  assign accept    = in_valid && (state_q == ST_IDLE);
  assign out_state = work_state;
  assign out_round = round_q;
  assign out_err   = err_q;

  // Key store: written in any state, out-of-range slots dropped, contents survive reset.
  always_ff @(posedge clk) begin
    if (key_we && (key_waddr <= NR_IDX)) begin
      key_mem[key_waddr] <= key_wdata;
    end
  end

  // Request decode: decrypt reverses slot order, out-of-range rounds use an all-zero key.
  always_comb begin
    req_err  = (in_round > NR_IDX);
    slot     = in_decrypt ? (NR_IDX - in_round) : in_round;
    slot_key = '0;
    if (!req_err) begin
      slot_key = key_mem[slot];
    end
  end

  // State register for the IDLE/RUN/DONE controller.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = cnt + 2'(g);
    addroundkey_col u_col (
      .state_col (col_sel(work_state, col_idx[g])),
      .key_col   (col_sel(work_key, col_idx[g])),
      .out_col   (xor_col[g])
    );
  end

  // Datapath: snapshot request and key on accept, then XOR a group of columns per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      work_state <= '0;
      work_key   <= '0;
      round_q    <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      cnt        <= '0;
      work_state <= in_state;
      work_key   <= slot_key;
      round_q    <= in_round;
      err_q      <= req_err;
    end else if (state_q == ST_RUN) begin
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
        work_state[BLOCK_W-1-COL_W*int'(col_idx[k]) -: COL_W] <= xor_col[k];
      end
      cnt <= cnt + STEP;
    end
  end

endmodule

// File: tb/tb_addroundkey_seq.sv
// tb/tb_addroundkey_seq.sv - directed self-checking bench for addroundkey_seq (COLS 4 and 1)
module tb_addroundkey_seq;

  localparam logic [127:0] KEY0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ONES   = {128{1'b1}};
  localparam logic [127:0] PT     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] R0_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] PT_INV = 128'hcdbc095777a5cf72cece675d1fc8f8cb;
  localparam logic [127:0] V5_IN  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] V5_OUT = 128'hfedcba98765432100123456789abcdef;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_we;
  logic [3:0]   key_waddr;
  logic [127:0] key_wdata;
  logic [127:0] in_state;
  logic [3:0]   in_round;
  logic         in_decrypt;
  logic         in_valid4, in_valid1;
  logic         out_ready4, out_ready1;

  logic         in_ready4, in_ready1;
  logic         out_valid4, out_valid1;
  logic [127:0] out_state4, out_state1;
  logic [3:0]   out_round4, out_round1;
  logic         out_err4, out_err1;
  logic         busy4, busy1;

  logic         sel;
  logic         obs_in_ready, obs_out_valid, obs_out_err, obs_busy;
  logic [127:0] obs_out_state;
  logic [3:0]   obs_out_round;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  addroundkey_seq #(.NR(10), .COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_state(in_state),
    .in_round(in_round), .in_decrypt(in_decrypt),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_state(out_state4),
    .out_round(out_round4), .out_err(out_err4), .busy(busy4)
  );

  addroundkey_seq #(.NR(10), .COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_state(in_state),
    .in_round(in_round), .in_decrypt(in_decrypt),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_state(out_state1),
    .out_round(out_round1), .out_err(out_err1), .busy(busy1)
  );

  assign obs_in_ready  = sel ? in_ready1  : in_ready4;
  assign obs_out_valid = sel ? out_valid1 : out_valid4;
  assign obs_out_state = sel ? out_state1 : out_state4;
  assign obs_out_round = sel ? out_round1 : out_round4;
  assign obs_out_err   = sel ? out_err1   : out_err4;
  assign obs_busy      = sel ? busy1      : busy4;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic key_write(input logic [3:0] a, input logic [127:0] d);
    key_we    = 1'b1;
    key_waddr = a;
    key_wdata = d;
    @(negedge clk);
    key_we    = 1'b0;
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic txn(input string tag, input bit use1, input logic [127:0] st,
                     input logic [3:0] rnd, input bit dec, input int hold, input bit rewrite,
                     input logic [127:0] exp_st, input bit exp_err, input int exp_lat);
    int lat;
    bit quiet;
    sel        = use1;
    in_state   = st;
    in_round   = rnd;
    in_decrypt = dec;
    if (use1) in_valid1 = 1'b1; else in_valid4 = 1'b1;
    check({tag, "/in_ready_idle"}, obs_in_ready, 1'b1);
    @(negedge clk);
    in_valid1 = 1'b0;
    in_valid4 = 1'b0;
    if (rewrite) begin
      key_we    = 1'b1;
      key_waddr = 4'd0;
      key_wdata = {4{32'h5a5a5a5a}};
    end
    lat   = 0;
    quiet = 1'b1;
    while (!obs_out_valid && lat < 20) begin
      if (obs_in_ready) quiet = 1'b0;
      @(negedge clk);
      key_we = 1'b0;
      lat++;
    end
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/in_ready_low_run"}, quiet, 1'b1);
    for (int i = 0; i < hold; i++) begin
      if (rewrite && i == 1) begin
        key_we    = 1'b1;
        key_waddr = 4'd0;
        key_wdata = ONES;
      end
      @(negedge clk);
      key_we = 1'b0;
      check({tag, "/held_valid"}, obs_out_valid, 1'b1);
      check({tag, "/held_state"}, obs_out_state, exp_st);
    end
    check({tag, "/out_state"}, obs_out_state, exp_st);
    check({tag, "/out_err"}, obs_out_err, exp_err);
    check({tag, "/out_round"}, obs_out_round, rnd);
    check({tag, "/in_ready_done"}, obs_in_ready, 1'b0);
    if (use1) out_ready1 = 1'b1; else out_ready4 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    out_ready4 = 1'b0;
    check({tag, "/valid_after_hs"}, obs_out_valid, 1'b0);
    check({tag, "/in_ready_after_hs"}, obs_in_ready, 1'b1);
    check({tag, "/busy_after_hs"}, obs_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit quiet;
    rst_n      = 1'b0;
    key_we     = 1'b0;
    key_waddr  = '0;
    key_wdata  = '0;
    in_state   = '0;
    in_round   = '0;
    in_decrypt = 1'b0;
    in_valid4  = 1'b0;
    in_valid1  = 1'b0;
    out_ready4 = 1'b0;
    out_ready1 = 1'b0;
    sel        = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      sel = (d == 1);
      #1;
      check("reset/out_valid", obs_out_valid, 1'b0);
      check("reset/out_state", obs_out_state, 128'h0);
      check("reset/out_round", obs_out_round, 4'd0);
      check("reset/out_err", obs_out_err, 1'b0);
      check("reset/busy", obs_busy, 1'b0);
      check("reset/in_ready", obs_in_ready, 1'b1);
    end
    @(negedge clk);

    key_write(4'd0, KEY0);
    key_write(4'd10, KEY10);
    key_write(4'd5, ONES);
    key_write(4'd11, 128'h0);

    txn("fips_c4",   1'b0, PT,     4'd0,  1'b0, 0, 1'b0, R0_OUT, 1'b0, 1);
    txn("fips_c1",   1'b1, PT,     4'd0,  1'b0, 0, 1'b0, R0_OUT, 1'b0, 4);
    txn("dec_r0",    1'b0, 128'h0, 4'd0,  1'b1, 0, 1'b0, KEY10,  1'b0, 1);
    txn("enc_r5",    1'b0, V5_IN,  4'd5,  1'b0, 0, 1'b0, V5_OUT, 1'b0, 1);
    txn("dec_r10",   1'b1, PT,     4'd10, 1'b1, 0, 1'b0, R0_OUT, 1'b0, 4);
    txn("enc_r10",   1'b0, 128'h0, 4'd10, 1'b0, 0, 1'b0, KEY10,  1'b0, 1);
    txn("oor_r11",   1'b0, PT,     4'd11, 1'b0, 0, 1'b0, PT,     1'b1, 1);
    txn("oor_dec",   1'b1, V5_IN,  4'd11, 1'b1, 0, 1'b0, V5_IN,  1'b1, 4);
    txn("backpress", 1'b1, PT,     4'd0,  1'b0, 5, 1'b1, R0_OUT, 1'b0, 4);
    txn("new_key0",  1'b0, PT,     4'd0,  1'b0, 0, 1'b0, PT_INV, 1'b0, 1);

    key_write(4'd0, KEY0);

    sel        = 1'b1;
    in_state   = PT;
    in_round   = 4'd0;
    in_decrypt = 1'b0;
    in_valid1  = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    check("rst_run/busy_in_run", busy1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_run/out_valid", out_valid1, 1'b0);
    check("rst_run/in_ready", in_ready1, 1'b1);
    check("rst_run/busy", busy1, 1'b0);
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid1) quiet = 1'b0;
    end
    check("rst_run/no_output", quiet, 1'b1);
    txn("after_rst", 1'b1, PT, 4'd0, 1'b0, 0, 1'b0, R0_OUT, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
